// File: rtl/str_rd_fifo_core.sv
// str_rd_fifo_core: AXI4-Lite readable packet FIFO fed by a valid/ready stream.
// Stream packets of N_PKT words are buffered; software reads the head packet
// word by word and the head pops once every word has been read.
module str_rd_fifo_core #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_PKT              = 3,
    parameter int DEPTH_LOG2         = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [32*N_PKT-1:0]             tdata,
    input  logic                            tvalid,
    output logic                            tready,
    output logic                            busy,
    output logic                            irq,
    input  logic [31:0]                     write_data_count,
    input  logic [31:0]                     read_data_count
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int OCC_W  = DEPTH_LOG2 + 1;
    localparam int PKT_W  = 32 * N_PKT;
    localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - 2;

    // Register word indices (byte address / 4)
    localparam logic [31:0] REG_WDC    = 32'd0;
    localparam logic [31:0] REG_RDC    = 32'd1;
    localparam logic [31:0] REG_STATUS = 32'd2;
    localparam logic [31:0] REG_CTRL   = 32'd3;
    localparam logic [31:0] REG_DROP   = 32'd4;
    localparam logic [31:0] REG_PKT    = 32'd5;
    localparam int          DATA_BASE  = 8;

    // AXI handshake state
    logic                          aw_ready;
    logic                          w_ready;
    logic                          b_valid;
    logic                          ar_ready;
    logic                          r_valid;
    logic [31:0]                   r_data;
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                          wr_en;
    logic                          rd_en;
    logic [31:0]                   wr_word32;
    logic [31:0]                   rd_word32;

    // Control and counters
    logic                          enable;
    logic                          drop_mode;
    logic                          irq_en;
    logic [31:0]                   drop_cnt;
    logic [31:0]                   pkt_cnt;
    logic                          live;
    logic                          irq_q;

    // Packet FIFO
    logic [PKT_W-1:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]         wr_ptr;
    logic [DEPTH_LOG2-1:0]         rd_ptr;
    logic [OCC_W-1:0]              occ;
    logic [N_PKT-1:0]              word_read;
    logic [PKT_W-1:0]              head_pkt;
    logic                          empty;
    logic                          full;

    // Derived strobes
    logic                          wr_ctrl;
    logic                          flush;
    logic                          wr_drop_clr;
    logic                          wr_pkt_clr;
    logic [N_PKT-1:0]              rd_hit;
    logic                          is_data;
    logic [31:0]                   head_word;
    logic                          data_rd;
    logic [N_PKT-1:0]              word_left;
    logic                          pop;
    logic                          tready_i;
    logic                          push_hs;
    logic                          push;
    logic                          drop;
    logic [31:0]                   status;
    logic [31:0]                   rd_mux;

    // Protection bits, sub-word address bits and upper data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], ar_addr[1:0],
                           S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                           S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:4]};

    assign wr_en     = aw_ready && S_AXI_AWVALID && w_ready && S_AXI_WVALID;
    assign rd_en     = ar_ready && S_AXI_ARVALID && !r_valid;
    assign wr_word32 = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign rd_word32 = 32'(ar_addr[C_S_AXI_ADDR_WIDTH-1:2]);

    assign empty    = (occ == '0);
    assign full     = (occ == OCC_W'(DEPTH));
    assign head_pkt = mem[rd_ptr];

    assign wr_ctrl     = wr_en && (wr_word32 == REG_CTRL) && S_AXI_WSTRB[0];
    assign flush       = wr_ctrl && S_AXI_WDATA[1];
    assign wr_drop_clr = wr_en && (wr_word32 == REG_DROP);
    assign wr_pkt_clr  = wr_en && (wr_word32 == REG_PKT);

    // Decode which head-packet word (if any) the latched read address selects
    always_comb begin
        rd_hit    = '0;
        head_word = '0;
        for (int k = 0; k < N_PKT; k++) begin
            if (rd_word32 == 32'(DATA_BASE + k)) begin
                rd_hit[k] = 1'b1;
                head_word = head_pkt[32*k +: 32];
            end
        end
    end

    assign is_data   = |rd_hit;
    assign data_rd   = rd_en && is_data && !empty;
    assign word_left = word_read & ~rd_hit;
    // Pop only on the read that clears the last outstanding word
    assign pop       = data_rd && (word_read != '0) && (word_left == '0);

    // In drop mode the stream is never stalled; full-FIFO offers become drops
    assign tready_i = live && enable && (drop_mode || !full);
    assign push_hs  = tvalid && tready_i;
    assign push     = push_hs && !flush && (!full || pop);
    assign drop     = push_hs && !flush && full && !pop;

    // Status word assembly
    always_comb begin
        status                = '0;
        status[N_PKT-1:0]     = word_read;
        status[16]            = empty;
        status[17]            = full;
        status[30:24]         = 7'(occ);
    end

    // Read data mux; unmapped addresses and empty-FIFO data reads return zero
    always_comb begin
        rd_mux = '0;
        case (rd_word32)
            REG_WDC:    rd_mux = write_data_count;
            REG_RDC:    rd_mux = read_data_count;
            REG_STATUS: rd_mux = status;
            REG_CTRL:   rd_mux = {28'd0, irq_en, drop_mode, 1'b0, enable};
            REG_DROP:   rd_mux = drop_cnt;
            REG_PKT:    rd_mux = pkt_cnt;
            default:    if (is_data && !empty) rd_mux = head_word;
        endcase
    end

    // Write address/data ready pulse and write response
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            if (!aw_ready && S_AXI_AWVALID && S_AXI_WVALID && !b_valid) begin
                aw_ready <= 1'b1;
                w_ready  <= 1'b1;
            end else begin
                aw_ready <= 1'b0;
                w_ready  <= 1'b0;
            end
            if (wr_en) begin
                b_valid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Read address ready pulse, address latch, registered read data
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_ready <= 1'b0;
            ar_addr  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (!ar_ready && S_AXI_ARVALID && !r_valid) begin
                ar_ready <= 1'b1;
                ar_addr  <= S_AXI_ARADDR;
            end else begin
                ar_ready <= 1'b0;
            end
            if (rd_en) begin
                r_valid <= 1'b1;
                r_data  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Control register; flush is a strobe and is not stored
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            enable    <= 1'b1;
            drop_mode <= 1'b0;
            irq_en    <= 1'b0;
        end else if (wr_ctrl) begin
            enable    <= S_AXI_WDATA[0];
            drop_mode <= S_AXI_WDATA[2];
            irq_en    <= S_AXI_WDATA[3];
        end
    end

    // Drop and packet counters; a software write wins over a same-cycle event
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            drop_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (wr_drop_clr) begin
                drop_cnt <= '0;
            end else if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (wr_pkt_clr) begin
                pkt_cnt <= '0;
            end else if (push) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    // FIFO pointers, occupancy and head word-read mask
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            word_read <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            word_read <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (pop) begin
                // A new head exists if more packets were queued or one arrives now
                word_read <= (occ > OCC_W'(1) || push) ? '1 : '0;
            end else if (push && empty) begin
                word_read <= '1;
            end else if (data_rd) begin
                word_read <= word_left;
            end
        end
    end

    // Packet storage at the tail
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) mem[wr_ptr] <= tdata;
    end

    // Stream enable after reset release, and registered interrupt level
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            live  <= 1'b1;
            irq_q <= irq_en && !empty;
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_valid;
    assign tready        = tready_i;
    assign busy          = !empty;
    assign irq           = irq_q;

endmodule
